// File: rtl/adc_sample_packer.sv
// Packs narrow ADC samples into LANES-slot words and queues them in a two-entry output buffer.
// Optional ramp test pattern source is built only when ADC_PACKER_TESTPAT_EN is defined.
module adc_sample_packer #(
    parameter int SAMPLE_W = 14,
    parameter int SLOT_W   = 16,
    parameter int LANES    = 4,
    parameter int SIGN_EXT = 0
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_sample_valid,
    input  logic [SAMPLE_W-1:0]       i_sample,
    input  logic                      i_flush,
    input  logic                      i_testpat,
    input  logic                      i_clear_overflow,
    output logic [LANES*SLOT_W-1:0]   o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_partial,
    output logic                      o_overflow,
    output logic [15:0]               o_drop_cnt
);

    localparam int WORD_W = LANES * SLOT_W;
    localparam int LANE_W = $clog2(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    logic [LANE_W-1:0]   lane;
    logic [WORD_W-1:0]   assembly;
    logic [WORD_W-1:0]   word_next;
    logic [WORD_W-1:0]   tail_data;
    logic                tail_partial;
    logic                tail_valid;
    logic [SAMPLE_W-1:0] sample_src;
    logic [SLOT_W-1:0]   slot_val;
    logic                complete;
    logic                push;
    logic                push_partial;
    logic                pop;
    logic                drop;

`ifdef ADC_PACKER_TESTPAT_EN
    logic [SAMPLE_W-1:0] ramp;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ramp <= '0;
        end else if (i_sample_valid && i_testpat) begin
            ramp <= ramp + SAMPLE_W'(1);
        end
    end

    assign sample_src = i_testpat ? ramp : i_sample;
`else
    logic unused_testpat;

    assign unused_testpat = i_testpat;
    assign sample_src     = i_sample;
`endif

    // The incoming sample is merged into the word before the flush decision,
    // so a flush in the same cycle carries that sample with it.
    always_comb begin
        slot_val = '0;
        slot_val[SAMPLE_W-1:0] = sample_src;
        for (int b = SAMPLE_W; b < SLOT_W; b++) begin
            slot_val[b] = (SIGN_EXT != 0) ? sample_src[SAMPLE_W-1] : 1'b0;
        end
        word_next = assembly;
        if (i_sample_valid) begin
            word_next[int'(lane)*SLOT_W +: SLOT_W] = slot_val;
        end
        complete     = i_sample_valid && (lane == LAST_LANE);
        push         = complete || (i_flush && (i_sample_valid || (lane != '0)));
        push_partial = !complete;
        pop          = o_valid && i_ready;
        drop         = push && !pop && tail_valid;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            lane     <= '0;
            assembly <= '0;
        end else if (push) begin
            lane     <= '0;
            assembly <= '0;
        end else if (i_sample_valid) begin
            lane     <= lane + LANE_W'(1);
            assembly <= word_next;
        end
    end

    // Head entry drives the outputs directly; the tail entry only refills it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_data       <= '0;
            o_partial    <= 1'b0;
            o_valid      <= 1'b0;
            tail_data    <= '0;
            tail_partial <= 1'b0;
            tail_valid   <= 1'b0;
        end else if (pop) begin
            if (tail_valid) begin
                o_data    <= tail_data;
                o_partial <= tail_partial;
                if (push) begin
                    tail_data    <= word_next;
                    tail_partial <= push_partial;
                end else begin
                    tail_valid <= 1'b0;
                end
            end else if (push) begin
                o_data    <= word_next;
                o_partial <= push_partial;
            end else begin
                o_valid <= 1'b0;
            end
        end else if (push) begin
            if (!o_valid) begin
                o_data    <= word_next;
                o_partial <= push_partial;
                o_valid   <= 1'b1;
            end else if (!tail_valid) begin
                tail_data    <= word_next;
                tail_partial <= push_partial;
                tail_valid   <= 1'b1;
            end
        end
    end

    // A drop coinciding with a clear restarts the count at one.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_overflow <= 1'b0;
            o_drop_cnt <= '0;
        end else if (drop) begin
            o_overflow <= 1'b1;
            if (i_clear_overflow) begin
                o_drop_cnt <= 16'd1;
            end else if (o_drop_cnt != 16'hFFFF) begin
                o_drop_cnt <= o_drop_cnt + 16'd1;
            end
        end else if (i_clear_overflow) begin
            o_overflow <= 1'b0;
            o_drop_cnt <= '0;
        end
    end

endmodule

// File: doc/adc_sample_packer.md
# adc_sample_packer

Parametrised successor to the fixed four-lane ADC test packer. It accepts a stream of narrow ADC samples on a strobe, places each one in a fixed-width slot of a wide output word, and hands completed words downstream over a valid/ready interface. A two-entry output buffer absorbs downstream stalls, and overflow is detected and counted. It sits between the ADC capture front end and the host/DMA word path.

## Interface
- SAMPLE_W, 14: ADC sample width in bits.
- SLOT_W, 16: slot width per lane; must be ≥ SAMPLE_W.
- LANES, 4: samples per output word; must be ≥ 2.
- SIGN_EXT, 0: slot padding above SAMPLE_W. 1 = replicate the sample MSB; 0 = zero-fill.
- i_clk  in  1  single clock for the whole block.
- i_reset  in  1  reset, asynchronous, active-high.
- i_sample_valid  in  1  sample strobe; one sample is accepted per high cycle.
- i_sample  in  SAMPLE_W  ADC sample.
- i_flush  in  1  single-cycle pulse; emits the current partial word.
- i_testpat  in  1  selects the internal ramp instead of i_sample (macro-dependent).
- i_clear_overflow  in  1  clears o_overflow and o_drop_cnt.
- o_data  out  LANES*SLOT_W  packed word; lane 0 occupies bits [SLOT_W-1:0].
- o_valid  out  1  o_data holds a word.
- i_ready  in  1  downstream accepts the word when o_valid && i_ready.
- o_partial  out  1  qualifies o_data: the word came from a flush.
- o_overflow  out  1  sticky; set when a completed word is dropped.
- o_drop_cnt  out  16  count of dropped words; saturates at 0xFFFF.

## Operation
**Reset values**
- o_data=0, o_valid=0, o_partial=0, o_overflow=0, o_drop_cnt=0.
- Lane counter=0, assembly register=0, buffer empty, ramp=0.

**Assembly**
- Each sample with i_sample_valid=1 is written into slot[lane], padded per SIGN_EXT.
- The lane counter then increments.
- When lane reaches LANES-1, the word is complete. The lane counter wraps to 0 and the assembly register clears to 0 for the next word.

**Flush**
- With i_flush=1 and lane>0, the partial word is pushed with its unfilled slots at 0, tagged partial, and lane is reset to 0.
- With i_flush=1 and lane=0, there is no effect.
- If i_flush and i_sample_valid are high in the same cycle, the sample is inserted first, then the flush applies. If that sample completes the word, the word is pushed once as a full word (partial=0).

**Buffer**
- Two-entry FIFO of {word, partial}; o_data/o_valid/o_partial present the head entry.
- Pop occurs on o_valid && i_ready.
- Push and pop in the same cycle is always allowed, including when the FIFO is full.
- A push while full with no pop is dropped: o_overflow is set to 1 and o_drop_cnt increments (saturating). FIFO contents are unchanged.

**Clear**
- i_clear_overflow zeroes o_overflow and o_drop_cnt.
- If a drop happens in the same cycle, the drop wins: overflow=1, count=1.

**Reset mid-word**
- The partial word is discarded and not emitted.
- Buffered words are lost.

## Timing
- Latency: the last-lane sample accepted in cycle N gives o_valid=1 in cycle N+1 when the FIFO is empty. The flush latency is the same.
- o_data and o_partial are stable while o_valid && !i_ready.
- No combinational path from i_ready to o_valid or o_data; all outputs are registered.
- Throughput: one sample per cycle is sustained indefinitely provided i_ready is high at least once every LANES cycles.
- Back-to-back words at LANES=2 with i_ready=1 produce one word every 2 cycles with no gaps or drops.

## Configuration
- ADC_PACKER_TESTPAT_EN defined:
  - When i_testpat=1, each accepted slot takes the ramp value instead of i_sample.
  - The ramp (SAMPLE_W bits) increments by 1 per accepted sample and wraps from 2^SAMPLE_W-1 to 0.
  - The ramp runs only while i_testpat=1 and holds its value otherwise; reset sets it to 0.
- Not defined:
  - i_testpat is ignored and no ramp logic is synthesised.
  - Samples always come from i_sample.

## Test plan
- Defaults, i_ready=1, samples 1,2,3,4 on consecutive cycles -> one cycle later o_data=0x0004_0003_0002_0001, o_valid for 1 cycle, o_partial=0.
- SIGN_EXT=1, sample 0x2001 in lane 0 -> slot 0 = 0xE001. SIGN_EXT=0 -> slot 0 = 0x2001.
- Samples 5,6, then i_flush -> o_data=0x0000_0000_0006_0005, o_partial=1. The next four samples pack from lane 0.
- i_ready=0, 12 samples streamed -> 2 words held, 3rd word dropped: o_overflow=1, o_drop_cnt=1. Raising i_ready delivers words 1 then 2 in order.
- Reset asserted after 2 of 4 samples -> all outputs 0. Next samples 9,10,11,12 -> 0x000C_000B_000A_0009.
- With ADC_PACKER_TESTPAT_EN, SAMPLE_W=14, i_testpat=1, 8 samples after reset -> words 0x0003_0002_0001_0000 then 0x0007_0006_0005_0004. Ramp after 0x3FFF returns to 0.
